// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared constants and helpers for the pipelined multiplier
package mul_pkg;

    localparam int MUL_LAT   = 4;
    // Widest value the negate helper handles; covers products of operands up to 128 bits.
    localparam int MUL_MAX_W = 256;

    function automatic int half_w(input int w);
        return w / 2;
    endfunction

    // Callers widen into MUL_MAX_W and cast back; the low bits of the negation are exact.
    function automatic logic [MUL_MAX_W-1:0] cond_neg(input logic [MUL_MAX_W-1:0] x,
                                                      input logic               neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/mul_half_pp.sv
// rtl/mul_half_pp.sv - registered HALF x HALF unsigned partial product
module mul_half_pp
    import mul_pkg::*;
#(
    parameter int HALF = 32
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iEn,
    input  logic              iClr,
    input  logic [HALF-1:0]   iA,
    input  logic [HALF-1:0]   iB,
    output logic [2*HALF-1:0] oP
);

    logic [2*HALF-1:0] r_p;
    logic [2*HALF-1:0] w_a_ext;
    logic [2*HALF-1:0] w_b_ext;

    assign w_a_ext = {{HALF{1'b0}}, iA};
    assign w_b_ext = {{HALF{1'b0}}, iB};

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_p <= '0;
        end else if (iClr) begin
            r_p <= '0;
        end else if (iEn) begin
            r_p <= w_a_ext * w_b_ext;
        end
    end

    assign oP = r_p;

endmodule

// File: rtl/multiplier_pipe_param.sv
// rtl/multiplier_pipe_param.sv - four-stage WIDTH x WIDTH signed/unsigned multiplier
// with valid/ready handshake, global stall and sideband tag.
module multiplier_pipe_param
    import mul_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAG_W = 4
) (
    input  logic               iClk,
    input  logic               iRstN,
    input  logic               iEn,
    input  logic               iClr,
    input  logic               iValid,
    output logic               oReady,
    input  logic               iSigned,
    input  logic [WIDTH-1:0]   iData0,
    input  logic [WIDTH-1:0]   iData1,
    input  logic [TAG_W-1:0]   iTag,
    output logic               oValid,
    input  logic               iReady,
    output logic [2*WIDTH-1:0] oData,
    output logic [TAG_W-1:0]   oTag
);

    localparam int HALF = half_w(WIDTH);
    localparam int PW   = 2 * WIDTH;
    localparam int MW   = WIDTH + 2;

    logic w_advance;

    // Stage 1 signals
    logic             w_neg_a;
    logic             w_neg_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] r_mag_a;
    logic [WIDTH-1:0] r_mag_b;
    logic             r_neg1;
    logic [TAG_W-1:0] r_tag1;
    logic             r_v1;

    // Stage 2 signals
    logic [WIDTH-1:0] w_pp_ll;
    logic [WIDTH-1:0] w_pp_hl;
    logic [WIDTH-1:0] w_pp_lh;
    logic [WIDTH-1:0] w_pp_hh;
    logic             r_neg2;
    logic [TAG_W-1:0] r_tag2;
    logic             r_v2;

    // Stage 3 signals
    logic [MW-1:0]    w_mid;
    logic [MW-1:0]    r_mid;
    logic [HALF-1:0]  r_ll_lo;
    logic [HALF-1:0]  r_hh_hi;
    logic             r_neg3;
    logic [TAG_W-1:0] r_tag3;
    logic             r_v3;

    // Stage 4 signals
    logic [HALF-1:0]  w_top;
    logic [PW-1:0]    w_mag;
    logic [PW-1:0]    w_res;
    logic [PW-1:0]    r_data;
    logic [TAG_W-1:0] r_tag;
    logic             r_v4;

    // A held result blocks the whole pipe; freeing the output slot frees every stage.
    assign w_advance = iEn & ~iClr & (~r_v4 | iReady);
    assign oReady    = w_advance;

    assign w_neg_a = iSigned & iData0[WIDTH-1];
    assign w_neg_b = iSigned & iData1[WIDTH-1];
    assign w_mag_a = WIDTH'(cond_neg(MUL_MAX_W'(iData0), w_neg_a));
    assign w_mag_b = WIDTH'(cond_neg(MUL_MAX_W'(iData1), w_neg_b));

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_neg1  <= 1'b0;
            r_tag1  <= '0;
            r_v1    <= 1'b0;
        end else if (iClr) begin
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_neg1  <= 1'b0;
            r_tag1  <= '0;
            r_v1    <= 1'b0;
        end else if (w_advance) begin
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
            r_neg1  <= w_neg_a ^ w_neg_b;
            r_tag1  <= iTag;
            r_v1    <= iValid;
        end
    end

    mul_half_pp #(.HALF(HALF)) u_pp_ll (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iEn   (w_advance),
        .iClr  (iClr),
        .iA    (r_mag_a[HALF-1:0]),
        .iB    (r_mag_b[HALF-1:0]),
        .oP    (w_pp_ll)
    );

    mul_half_pp #(.HALF(HALF)) u_pp_hl (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iEn   (w_advance),
        .iClr  (iClr),
        .iA    (r_mag_a[WIDTH-1:HALF]),
        .iB    (r_mag_b[HALF-1:0]),
        .oP    (w_pp_hl)
    );

    mul_half_pp #(.HALF(HALF)) u_pp_lh (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iEn   (w_advance),
        .iClr  (iClr),
        .iA    (r_mag_a[HALF-1:0]),
        .iB    (r_mag_b[WIDTH-1:HALF]),
        .oP    (w_pp_lh)
    );

    mul_half_pp #(.HALF(HALF)) u_pp_hh (
        .iClk  (iClk),
        .iRstN (iRstN),
        .iEn   (w_advance),
        .iClr  (iClr),
        .iA    (r_mag_a[WIDTH-1:HALF]),
        .iB    (r_mag_b[WIDTH-1:HALF]),
        .oP    (w_pp_hh)
    );

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_neg2 <= 1'b0;
            r_tag2 <= '0;
            r_v2   <= 1'b0;
        end else if (iClr) begin
            r_neg2 <= 1'b0;
            r_tag2 <= '0;
            r_v2   <= 1'b0;
        end else if (w_advance) begin
            r_neg2 <= r_neg1;
            r_tag2 <= r_tag1;
            r_v2   <= r_v1;
        end
    end

    // Middle column: cross products plus the parts of ll/hh overlapping bits HALF..WIDTH+HALF-1.
    assign w_mid = {2'b00, w_pp_hl}
                 + {2'b00, w_pp_lh}
                 + {2'b00, w_pp_hh[HALF-1:0], w_pp_ll[WIDTH-1:HALF]};

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_mid   <= '0;
            r_ll_lo <= '0;
            r_hh_hi <= '0;
            r_neg3  <= 1'b0;
            r_tag3  <= '0;
            r_v3    <= 1'b0;
        end else if (iClr) begin
            r_mid   <= '0;
            r_ll_lo <= '0;
            r_hh_hi <= '0;
            r_neg3  <= 1'b0;
            r_tag3  <= '0;
            r_v3    <= 1'b0;
        end else if (w_advance) begin
            r_mid   <= w_mid;
            r_ll_lo <= w_pp_ll[HALF-1:0];
            r_hh_hi <= w_pp_hh[WIDTH-1:HALF];
            r_neg3  <= r_neg2;
            r_tag3  <= r_tag2;
            r_v3    <= r_v2;
        end
    end

    assign w_top = r_hh_hi + HALF'(r_mid[WIDTH+1:WIDTH]);
    assign w_mag = {w_top, r_mid[WIDTH-1:0], r_ll_lo};
    assign w_res = PW'(cond_neg(MUL_MAX_W'(w_mag), r_neg3));

    // Bubbles load zeros so the output reads 0 whenever oValid is low.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_data <= '0;
            r_tag  <= '0;
            r_v4   <= 1'b0;
        end else if (iClr) begin
            r_data <= '0;
            r_tag  <= '0;
            r_v4   <= 1'b0;
        end else if (w_advance) begin
            r_data <= r_v3 ? w_res  : '0;
            r_tag  <= r_v3 ? r_tag3 : '0;
            r_v4   <= r_v3;
        end
    end

    assign oValid = r_v4;
    assign oData  = r_data;
    assign oTag   = r_tag;

endmodule

// File: tb/tb_multiplier_pipe_param.sv
// tb/tb_multiplier_pipe_param.sv - directed and random checks of multiplier_pipe_param
module tb_multiplier_pipe_param;
    import mul_pkg::*;

    localparam int W  = 64;
    localparam int TW = 4;

    logic            iClk = 1'b0;
    logic            iRstN;
    logic            iEn;
    logic            iClr;
    logic            iValid;
    logic            oReady;
    logic            iSigned;
    logic [W-1:0]    iData0;
    logic [W-1:0]    iData1;
    logic [TW-1:0]   iTag;
    logic            oValid;
    logic            iReady;
    logic [2*W-1:0]  oData;
    logic [TW-1:0]   oTag;

    multiplier_pipe_param #(.WIDTH(W), .TAG_W(TW)) dut (
        .iClk    (iClk),
        .iRstN   (iRstN),
        .iEn     (iEn),
        .iClr    (iClr),
        .iValid  (iValid),
        .oReady  (oReady),
        .iSigned (iSigned),
        .iData0  (iData0),
        .iData1  (iData1),
        .iTag    (iTag),
        .oValid  (oValid),
        .iReady  (iReady),
        .oData   (oData),
        .oTag    (oTag)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [127:0] d;
        logic [3:0]   t;
    } exp_t;

    exp_t         exp_q[$];
    int           n_pass  = 0;
    int           n_total = 0;
    int           run     = 0;
    int           max_run = 0;
    int           n_out   = 0;
    int           out_mark;
    logic [127:0] snap_d;
    logic [3:0]   snap_t;
    logic         snap_v;

    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                             input logic s);
        logic [127:0] ea;
        logic [127:0] eb;
        ea = s ? {{64{a[63]}}, a} : {64'b0, a};
        eb = s ? {{64{b[63]}}, b} : {64'b0, b};
        return ea * eb;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic put(input logic v, input logic s, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] t);
        iValid  = v;
        iSigned = s;
        iData0  = a;
        iData1  = b;
        iTag    = t;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // One cycle: score the current handshake, then advance to the next falling edge.
    task automatic tick();
        exp_t e;
        #1;
        if (oValid) run++; else run = 0;
        if (run > max_run) max_run = run;
        if (iRstN && iEn && !iClr && oValid && iReady) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_out", 128'(oValid), 128'(0));
            end else begin
                e = exp_q.pop_front();
                check("data", oData, e.d);
                check("tag", 128'(oTag), 128'(e.t));
            end
        end
        if (iRstN && iValid && oReady) begin
            e.d = ref_mul(iData0, iData1, iSigned);
            e.t = iTag;
            exp_q.push_back(e);
        end
        if (iRstN && iClr) exp_q.delete();
        @(posedge iClk);
        @(negedge iClk);
    endtask

    initial begin
        logic [63:0] sa[4];
        logic [63:0] sb[4];

        iRstN  = 1'b0;
        iEn    = 1'b1;
        iClr   = 1'b0;
        iReady = 1'b1;
        put(0, 0, 0, 0, 0);
        repeat (2) @(negedge iClk);
        #1;
        check("reset_valid", 128'(oValid), 128'(0));
        check("reset_data", oData, 128'(0));
        check("reset_tag", 128'(oTag), 128'(0));
        iRstN = 1'b1;
        #1;
        check("ready_after_reset", 128'(oReady), 128'(1));

        // Unsigned max with latency
        put(1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'hA);
        tick();
        put(0, 0, 0, 0, 0);
        for (int k = 1; k < MUL_LAT; k++) begin
            #1 check("lat_umax_early", 128'(oValid), 128'(0));
            tick();
        end
        #1;
        check("lat_umax_valid", 128'(oValid), 128'(1));
        check("umax_data", oData, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
        check("umax_tag", 128'(oTag), 128'(4'hA));
        tick();

        // Signed edge cases
        sa[0] = 64'hFFFF_FFFF_FFFF_FFFF; sb[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        sa[1] = 64'hFFFF_FFFF_FFFF_FFFD; sb[1] = 64'd5;
        sa[2] = 64'h8000_0000_0000_0000; sb[2] = 64'h8000_0000_0000_0000;
        sa[3] = 64'd0;                   sb[3] = 64'hFFFF_FFFF_FFFF_FFF9;
        for (int i = 0; i < 4; i++) begin
            put(1, 1, sa[i], sb[i], 4'(i));
            tick();
        end
        put(0, 0, 0, 0, 0);
        repeat (6) tick();
        check("signed_drained", 128'(exp_q.size()), 128'(0));

        // Streaming
        run = 0;
        max_run = 0;
        for (int i = 0; i < 8; i++) begin
            put(1, 0, 64'(i), 64'(i + 1), 4'(i));
            tick();
        end
        put(0, 0, 0, 0, 0);
        repeat (6) tick();
        check("stream_run", 128'(max_run), 128'(8));
        check("stream_drained", 128'(exp_q.size()), 128'(0));

        // Backpressure with full pipe
        for (int i = 0; i < 6; i++) begin
            put(1, 1'($urandom), rnd64(), rnd64(), 4'(i));
            tick();
        end
        iReady = 1'b0;
        put(1, 1'($urandom), rnd64(), rnd64(), 4'd9);
        #1;
        check("bp_full_valid", 128'(oValid), 128'(1));
        snap_d = oData;
        snap_t = oTag;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_ready_low", 128'(oReady), 128'(0));
            check("bp_data_hold", oData, snap_d);
            check("bp_tag_hold", 128'(oTag), 128'(snap_t));
            tick();
        end
        iReady = 1'b1;
        #1 check("bp_pending_accept", 128'(oReady), 128'(1));
        tick();
        put(0, 0, 0, 0, 0);
        repeat (6) tick();
        check("bp_drained", 128'(exp_q.size()), 128'(0));

        // Enable freeze mid-stream
        for (int i = 0; i < 5; i++) begin
            put(1, 1'($urandom), rnd64(), rnd64(), 4'($urandom));
            tick();
        end
        iEn    = 1'b0;
        iReady = 1'b0;
        put(1, 0, rnd64(), rnd64(), 4'hC);
        #1;
        snap_v = oValid;
        snap_d = oData;
        snap_t = oTag;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("en_ready_low", 128'(oReady), 128'(0));
            check("en_valid_hold", 128'(oValid), 128'(snap_v));
            check("en_data_hold", oData, snap_d);
            check("en_tag_hold", 128'(oTag), 128'(snap_t));
            tick();
        end
        iEn    = 1'b1;
        iReady = 1'b1;
        put(0, 0, 0, 0, 0);
        repeat (7) tick();
        check("en_drained", 128'(exp_q.size()), 128'(0));

        // Clear with ops in flight
        iReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(1, 0, rnd64(), rnd64(), 4'(i + 4));
            tick();
        end
        iClr = 1'b1;
        put(1, 0, 64'd3, 64'd3, 4'hE);
        #1 check("clr_ready_low", 128'(oReady), 128'(0));
        tick();
        iClr = 1'b0;
        put(0, 0, 0, 0, 0);
        #1;
        check("clr_valid", 128'(oValid), 128'(0));
        check("clr_data", oData, 128'(0));
        check("clr_tag", 128'(oTag), 128'(0));
        iReady = 1'b1;
        out_mark = n_out;
        repeat (8) tick();
        check("clr_no_ghosts", 128'(n_out - out_mark), 128'(0));

        // Asynchronous reset mid-operation
        iReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(1, 1, rnd64(), rnd64(), 4'(i));
            tick();
        end
        put(0, 0, 0, 0, 0);
        #2 iRstN = 1'b0;
        #1;
        check("arst_valid", 128'(oValid), 128'(0));
        check("arst_data", oData, 128'(0));
        check("arst_tag", 128'(oTag), 128'(0));
        exp_q.delete();
        @(posedge iClk);
        @(negedge iClk);
        iRstN  = 1'b1;
        iReady = 1'b1;
        put(1, 0, 64'd7, 64'd6, 4'd3);
        tick();
        put(0, 0, 0, 0, 0);
        for (int k = 1; k < MUL_LAT; k++) begin
            #1 check("lat_post_rst_early", 128'(oValid), 128'(0));
            tick();
        end
        #1;
        check("post_rst_valid", 128'(oValid), 128'(1));
        check("post_rst_data", oData, 128'd42);
        check("post_rst_tag", 128'(oTag), 128'(4'd3));
        repeat (4) tick();
        check("final_drained", 128'(exp_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
